// File: rtl/mux16_scan_ctrl_pkg.sv
// Shared types and constants for the 16-channel mux scan sequencer.
package mux16_scan_pkg;
  localparam int NCH  = 16;
  localparam int SELW = 4;
  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2
  } state_e;
endpackage

// File: rtl/mux16_scan_ctrl_if.sv
// Control/data bundle between the scan sequencer and its environment (mux + host).
interface mux16_scan_ctrl_if;
  import mux16_scan_pkg::*;

  logic             i_start;
  logic             i_cont;
  logic [SELW-1:0]  i_first;
  logic [SELW-1:0]  i_last;
  logic             i_f;
  logic [SELW-1:0]  o_s16;
  logic [0:NCH-1]   o_q;
  logic             o_busy;
  logic             o_done;

  modport master (output i_start, i_cont, i_first, i_last, i_f,
                  input  o_s16, o_q, o_busy, o_done);
  modport slave  (input  i_start, i_cont, i_first, i_last, i_f,
                  output o_s16, o_q, o_busy, o_done);
endinterface

// File: rtl/mux16_scan_ctrl_settle_timer.sv
// Loadable down-counter; expired is high once the count is at 1 or below.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expired
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (i_load)        r_cnt <= i_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt <= W'(1));
endmodule

// File: rtl/mux16_scan_ctrl.sv
// Sweeps the mux select over First..Last (with wrap) and captures f per channel into Q.
module mux16_scan_ctrl
  import mux16_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  mux16_scan_ctrl_if.slave bus
);
  localparam logic [CNTW-1:0] SETTLE_V = CNTW'(SETTLE);
  // Every new channel starts in WAIT unless there is no settle time to spend.
  localparam state_e CH_ST = (SETTLE == 0) ? SAMPLE : WAIT;

  state_e          r_state;
  logic [SELW-1:0] r_first;
  logic [SELW-1:0] r_last;
  logic [SELW-1:0] r_s16;
  logic [0:NCH-1]  r_q;
  logic            r_busy;
  logic            r_done;

  logic w_at_last;
  logic w_load;
  logic w_expired;

  assign w_at_last = (r_s16 == r_last);
  assign w_load    = ((r_state == IDLE) && bus.i_start) ||
                     ((r_state == SAMPLE) && (!w_at_last || bus.i_cont));

  settle_timer #(.W(CNTW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_val     (SETTLE_V),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_first <= '0;
      r_last  <= '0;
      r_s16   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_first <= bus.i_first;
            r_last  <= bus.i_last;
            r_s16   <= bus.i_first;
            r_busy  <= 1'b1;
            r_state <= CH_ST;
          end
        end
        WAIT: begin
          if (w_expired) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_q[r_s16] <= bus.i_f;
          if (!w_at_last) begin
            r_s16   <= r_s16 + 1'b1;
            r_state <= CH_ST;
          end else begin
            r_done <= 1'b1;
            // Cont is only looked at here, so dropping it mid-sweep lets the sweep finish.
            if (bus.i_cont) begin
              r_s16   <= r_first;
              r_state <= CH_ST;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_s16  = r_s16;
  assign bus.o_q    = r_q;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Scoreboard bench: two sequencers (SETTLE=0 and SETTLE=3) around model muxes.
module tb_mux16_scan_ctrl;
  import mux16_scan_pkg::*;

  typedef struct {
    logic [0:15] q;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [0:15] wa, wb;
  logic [0:15] ma, mb;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux16_scan_ctrl_if ifa ();
  mux16_scan_ctrl_if ifb ();

  assign ifa.i_f = wa[ifa.o_s16];
  assign ifb.i_f = wb[ifb.o_s16];

  mux16_scan_ctrl #(.SETTLE(0)) u_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
  mux16_scan_ctrl #(.SETTLE(3)) u_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event not as required (cycle %0d)", nm, cyc);
  endtask

  // Reference: every channel from f to l (mod 16) takes w's bit; others untouched.
  task automatic sweep(inout logic [0:15] m, input logic [0:15] w,
                       input int f, input int l, output int n);
    int ch;
    n = 0;
    do begin
      ch = (f + n) % 16;
      m[ch] = w[ch];
      n++;
    end while (ch != l);
  endtask

  always @(negedge clk) begin
    if (!rst_a && ifa.o_done === 1'b1) begin
      if (qa.size() == 0) fail("a_unexpected_done");
      else begin
        ea = qa.pop_front();
        chk("a_q", 32'(ifa.o_q), 32'(ea.q));
        chk("a_done_cycle", cyc, ea.at);
      end
    end
    if (!rst_b && ifb.o_done === 1'b1) begin
      if (qb.size() == 0) fail("b_unexpected_done");
      else begin
        eb = qb.pop_front();
        chk("b_q", 32'(ifb.o_q), 32'(eb.q));
        chk("b_done_cycle", cyc, eb.at);
      end
    end
  end

  task automatic start_a(input logic [3:0] f, input logic [3:0] l);
    exp_t e;
    int n;
    @(negedge clk);
    ifa.i_first = f; ifa.i_last = l; ifa.i_cont = 1'b0; ifa.i_start = 1'b1;
    sweep(ma, wa, int'(f), int'(l), n);
    e.q = ma; e.at = cyc + 1 + n;
    qa.push_back(e);
    @(negedge clk);
    ifa.i_start = 1'b0;
  endtask

  task automatic start_b(input logic [3:0] f, input logic [3:0] l);
    exp_t e;
    int n;
    @(negedge clk);
    ifb.i_first = f; ifb.i_last = l; ifb.i_cont = 1'b0; ifb.i_start = 1'b1;
    sweep(mb, wb, int'(f), int'(l), n);
    e.q = mb; e.at = cyc + 1 + n * 4;
    qb.push_back(e);
    @(negedge clk);
    ifb.i_start = 1'b0;
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while ((qa.size() != 0 || ifa.o_busy !== 1'b0) && k < 300) begin
      @(negedge clk); k++;
    end
    if (k >= 300) fail("a_idle_timeout");
  endtask

  task automatic wait_idle_b();
    int k = 0;
    while ((qb.size() != 0 || ifb.o_busy !== 1'b0) && k < 600) begin
      @(negedge clk); k++;
    end
    if (k >= 600) fail("b_idle_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [3:0] f, l;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.i_start = 0; ifa.i_cont = 0; ifa.i_first = 0; ifa.i_last = 0;
    ifb.i_start = 0; ifb.i_cont = 0; ifb.i_first = 0; ifb.i_last = 0;
    wa = '0; wb = '0; ma = '0; mb = '0;
    repeat (3) @(negedge clk);
    chk("rst_s16", 32'(ifa.o_s16), 0);
    chk("rst_q", 32'(ifa.o_q), 0);
    chk("rst_busy", 32'(ifa.o_busy), 0);
    chk("rst_done", 32'(ifa.o_done), 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Full sweep 0..15 with per-cycle select stepping
    wa = 16'hA5C3;
    start_a(4'd0, 4'd15);
    for (int i = 0; i < 16; i++) begin
      chk("full_s16_step", 32'(ifa.o_s16), 32'(i));
      chk("full_busy", 32'(ifa.o_busy), 1);
      @(negedge clk);
    end
    chk("full_busy_fall", 32'(ifa.o_busy), 0);
    chk("full_q", 32'(ifa.o_q), 32'h0000A5C3);
    wait_idle_a();

    // Wrap sweep from a cleared Q
    @(negedge clk); rst_a = 1'b1; qa.delete(); ma = '0;
    @(negedge clk); rst_a = 1'b0;
    wa = 16'hFFFF;
    start_a(4'd14, 4'd1);
    wait_idle_a();
    chk("wrap_q", 32'(ifa.o_q), 32'h0000C003);

    // Random sweeps; a Start issued while busy must be ignored
    for (int t = 0; t < 10; t++) begin
      wa = 16'($urandom);
      f = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 15));
      start_a(f, l);
      ifa.i_first = ~f; ifa.i_last = l + 4'd3; ifa.i_start = 1'b1;
      @(negedge clk); ifa.i_start = 1'b0;
      wait_idle_a();
    end

    // Continuous 0..3; drop Cont during the third sweep
    wa = 16'($urandom);
    @(negedge clk);
    c0 = cyc;
    ifa.i_first = 0; ifa.i_last = 3; ifa.i_cont = 1'b1; ifa.i_start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      int n;
      sweep(ma, wa, 0, 3, n);
      ea.q = ma; ea.at = c0 + 1 + 4 * k;
      qa.push_back(ea);
    end
    @(negedge clk); ifa.i_start = 1'b0;
    repeat (9) begin
      chk("cont_busy", 32'(ifa.o_busy), 1);
      @(negedge clk);
    end
    ifa.i_cont = 1'b0;
    wait_idle_a();
    chk("cont_end_busy", 32'(ifa.o_busy), 0);

    // Asynchronous reset mid-sweep
    wa = 16'hFFFF;
    start_a(4'd0, 4'd15);
    c0 = cyc;
    repeat (6) @(negedge clk);
    chk("mid_s16", 32'(ifa.o_s16), 32'(cyc - c0));
    #2 rst_a = 1'b1; qa.delete(); ma = '0;
    #1;
    chk("arst_s16", 32'(ifa.o_s16), 0);
    chk("arst_q", 32'(ifa.o_q), 0);
    chk("arst_busy", 32'(ifa.o_busy), 0);
    chk("arst_done", 32'(ifa.o_done), 0);
    @(negedge clk); rst_a = 1'b0;

    // SETTLE=3, single channel 5
    wb = 16'($urandom); wb[5] = 1'b1;
    start_b(4'd5, 4'd5);
    for (int i = 0; i < 4; i++) begin
      chk("settle_s16_hold", 32'(ifb.o_s16), 5);
      chk("settle_q5_pre", 32'(ifb.o_q[5]), 0);
      @(negedge clk);
    end
    chk("settle_q5", 32'(ifb.o_q[5]), 1);
    chk("settle_done", 32'(ifb.o_done), 1);
    @(negedge clk);
    chk("settle_done_pulse", 32'(ifb.o_done), 0);
    wait_idle_b();

    for (int t = 0; t < 4; t++) begin
      wb = 16'($urandom);
      start_b(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      wait_idle_b();
    end

    repeat (3) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) fail("leftover_expectations");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
